// File: rtl/siggen_pkg.sv
// Shared encodings and constants for the signal-generator configuration sequencer.
// Holds waveform codes, frame constants and parser states.
package siggen_pkg;

    typedef enum logic [1:0] {
        SIG_SQUARE = 2'b00,
        SIG_SINE   = 2'b01,
        SIG_SAW    = 2'b10,
        SIG_TRI    = 2'b11
    } sig_type_t;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam logic [7:0] CSUM_KEY       = 8'h5A;

    typedef enum logic [1:0] {
        P_IDLE,
        P_GET_F,
        P_GET_C,
        P_GET_K
    } parser_state_t;

    function automatic logic [7:0] frame_csum(input logic [7:0] f, input logic [7:0] c);
        return f ^ c ^ CSUM_KEY;
    endfunction

endpackage

// File: rtl/siggen_cfg_sequencer_if.sv
// Byte stream from the USART receiver into the configuration sequencer.
interface siggen_cfg_sequencer_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/siggen_frame_parser.sv
// Frame parser: header/fin/control/checksum FSM plus inter-byte gap timeout.
// frame_ok and frame_err are same-cycle strobes qualified by the final byte or the timeout.
module siggen_frame_parser
    import siggen_pkg::*;
#(
    parameter logic [7:0] HEADER      = HEADER_DEFAULT,
    parameter int         GAP_TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       frame_ok,
    output logic [7:0] frame_fin,
    output logic [3:0] frame_ain,
    output logic [1:0] frame_type,
    output logic       frame_err
);

    localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);

    parser_state_t    state;
    logic [GAP_W-1:0] gap_cnt;
    logic [7:0]       f_reg;
    logic [7:0]       c_reg;
    logic             timeout;
    logic             csum_ok;
    logic             last_byte;

    assign timeout    = (state != P_IDLE) && !rx_valid && (gap_cnt == GAP_W'(GAP_TIMEOUT));
    // Reserved control bits set are treated exactly like a bad checksum.
    assign csum_ok    = (rx_data == frame_csum(f_reg, c_reg)) && (c_reg[5:4] == 2'b00);
    assign last_byte  = rx_valid && (state == P_GET_K);
    assign frame_ok   = last_byte && csum_ok;
    assign frame_err  = (last_byte && !csum_ok) || timeout;
    assign frame_fin  = f_reg;
    assign frame_ain  = c_reg[3:0];
    assign frame_type = c_reg[7:6];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= P_IDLE;
            gap_cnt <= '0;
            f_reg   <= '0;
            c_reg   <= '0;
        end else if (rx_valid) begin
            gap_cnt <= '0;
            case (state)
                P_IDLE:  if (rx_data == HEADER) state <= P_GET_F;
                P_GET_F: begin f_reg <= rx_data; state <= P_GET_C; end
                P_GET_C: begin c_reg <= rx_data; state <= P_GET_K; end
                P_GET_K: state <= P_IDLE;
                default: state <= P_IDLE;
            endcase
        end else if (timeout) begin
            state   <= P_IDLE;
            gap_cnt <= '0;
        end else if (state != P_IDLE) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/siggen_cfg_sequencer.sv
// Configuration sequencer: validated frames wait in a single pending slot and are
// applied at a waveform period boundary (or after a force timeout). Optional readback: SIGGEN_CFG_READBACK_EN.
module siggen_cfg_sequencer
    import siggen_pkg::*;
#(
    parameter logic [7:0] HEADER        = HEADER_DEFAULT,
    parameter int         GAP_TIMEOUT   = 50000,
    parameter int         FORCE_TIMEOUT = 5000000
) (
    input  logic                   clk,
    input  logic                   reset,
    siggen_cfg_sequencer_if.slave  rx,
    input  logic                   period_start,
    output logic [7:0]             fin,
    output logic [3:0]             ain,
    output logic [1:0]             sig_type,
    output logic                   cfg_update,
    output logic                   pending,
    output logic                   frame_err,
    output logic [7:0]             err_count
`ifdef SIGGEN_CFG_READBACK_EN
    ,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready
`endif
);

    localparam int FORCE_W = $clog2(FORCE_TIMEOUT + 1);

    logic               frame_ok;
    logic               parse_err;
    logic [7:0]         frame_fin;
    logic [3:0]         frame_ain;
    logic [1:0]         frame_type;
    logic [7:0]         pend_fin;
    logic [3:0]         pend_ain;
    logic [1:0]         pend_type;
    logic [FORCE_W-1:0] force_cnt;
    logic               apply;

    siggen_frame_parser #(
        .HEADER      (HEADER),
        .GAP_TIMEOUT (GAP_TIMEOUT)
    ) u_parser (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx.rx_data),
        .rx_valid   (rx.rx_valid),
        .frame_ok   (frame_ok),
        .frame_fin  (frame_fin),
        .frame_ain  (frame_ain),
        .frame_type (frame_type),
        .frame_err  (parse_err)
    );

    assign apply = pending && (period_start || (force_cnt == FORCE_W'(FORCE_TIMEOUT)));

    // force_cnt reloads with 1 so the apply lands exactly FORCE_TIMEOUT edges after pending rose.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fin        <= '0;
            ain        <= '0;
            sig_type   <= SIG_TRI;
            cfg_update <= 1'b0;
            pending    <= 1'b0;
            pend_fin   <= '0;
            pend_ain   <= '0;
            pend_type  <= '0;
            force_cnt  <= '0;
            frame_err  <= 1'b0;
            err_count  <= '0;
        end else begin
            cfg_update <= apply;
            if (apply) begin
                fin      <= pend_fin;
                ain      <= pend_ain;
                sig_type <= pend_type;
            end
            if (frame_ok) begin
                pend_fin  <= frame_fin;
                pend_ain  <= frame_ain;
                pend_type <= frame_type;
                pending   <= 1'b1;
                force_cnt <= FORCE_W'(1);
            end else if (apply) begin
                pending   <= 1'b0;
                force_cnt <= '0;
            end else if (pending) begin
                force_cnt <= force_cnt + 1'b1;
            end
            frame_err <= parse_err;
            if (parse_err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
        end
    end

`ifdef SIGGEN_CFG_READBACK_EN
    logic       rb_busy;
    logic       rb_queued;
    logic [1:0] rb_idx;
    logic [7:0] rb_fin;
    logic [7:0] rb_ctl;
    logic [7:0] nxt_fin;
    logic [7:0] nxt_ctl;

    // Snapshot source is the value the outputs hold after this edge.
    assign nxt_fin  = apply ? pend_fin : fin;
    assign nxt_ctl  = apply ? {pend_type, 2'b00, pend_ain} : {sig_type, 2'b00, ain};
    assign tx_valid = rb_busy;
    assign tx_data  = (rb_idx == 2'd0) ? HEADER : ((rb_idx == 2'd1) ? rb_fin : rb_ctl);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rb_busy   <= 1'b0;
            rb_queued <= 1'b0;
            rb_idx    <= '0;
            rb_fin    <= '0;
            rb_ctl    <= '0;
        end else if (rb_busy && tx_ready && (rb_idx == 2'd2)) begin
            if (rb_queued || apply) begin
                rb_idx    <= '0;
                rb_fin    <= nxt_fin;
                rb_ctl    <= nxt_ctl;
                rb_queued <= 1'b0;
            end else begin
                rb_busy <= 1'b0;
            end
        end else if (rb_busy) begin
            if (tx_ready) rb_idx <= rb_idx + 2'd1;
            if (apply) rb_queued <= 1'b1;
        end else if (apply) begin
            rb_busy <= 1'b1;
            rb_idx  <= '0;
            rb_fin  <= nxt_fin;
            rb_ctl  <= nxt_ctl;
        end
    end
`endif

endmodule

// File: tb/tb_siggen_cfg_sequencer.sv
// Directed bench for siggen_cfg_sequencer with shortened gap/force timeouts.
module tb_siggen_cfg_sequencer;
    import siggen_pkg::*;

    localparam int GAP_T   = 40;
    localparam int FORCE_T = 300;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       period_start = 1'b0;
    logic [7:0] fin;
    logic [3:0] ain;
    logic [1:0] sig_type;
    logic       cfg_update;
    logic       pending;
    logic       frame_err;
    logic [7:0] err_count;
`ifdef SIGGEN_CFG_READBACK_EN
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
`endif

    int n_vec = 0;
    int n_err = 0;

    siggen_cfg_sequencer_if rx_bus ();

    siggen_cfg_sequencer #(
        .HEADER        (8'hA5),
        .GAP_TIMEOUT   (GAP_T),
        .FORCE_TIMEOUT (FORCE_T)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx_bus.slave),
        .period_start (period_start),
        .fin          (fin),
        .ain          (ain),
        .sig_type     (sig_type),
        .cfg_update   (cfg_update),
        .pending      (pending),
        .frame_err    (frame_err),
        .err_count    (err_count)
`ifdef SIGGEN_CFG_READBACK_EN
        ,
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic ps);
        rx_bus.rx_data  = b;
        rx_bus.rx_valid = 1'b1;
        period_start    = ps;
        tick(1);
        rx_bus.rx_valid = 1'b0;
        period_start    = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f, input logic [7:0] c, input logic [7:0] k);
        send(8'hA5, 1'b0);
        send(f, 1'b0);
        send(c, 1'b0);
        send(k, 1'b0);
    endtask

    task automatic pulse_period();
        period_start = 1'b1;
        tick(1);
        period_start = 1'b0;
    endtask

    initial begin
        int n;
        rx_bus.rx_data  = 8'h00;
        rx_bus.rx_valid = 1'b0;
        tick(3);
        check("rst_fin", fin, 8'h00);
        check("rst_ain", ain, 4'h0);
        check("rst_type", sig_type, 2'b11);
        check("rst_pending", pending, 1'b0);
        check("rst_upd", cfg_update, 1'b0);
        check("rst_err", {frame_err, err_count}, 9'h000);
        reset = 1'b1;
        tick(2);

        // Basic frame, applied at a period boundary 100 cycles later
        send_frame(8'h40, 8'h87, 8'h9D);
        check("t1_pending", pending, 1'b1);
        check("t1_fin_hold", fin, 8'h00);
        tick(100);
        check("t1_still_pend", {pending, cfg_update}, 2'b10);
        pulse_period();
        check("t1_cfg", {fin, ain, sig_type}, {8'h40, 4'h7, 2'b10});
        check("t1_upd", {cfg_update, pending}, 2'b10);
        tick(1);
        check("t1_upd_end", cfg_update, 1'b0);

        // Bad checksum
        send_frame(8'h40, 8'h87, 8'h00);
        check("t2_err", {frame_err, err_count}, {1'b1, 8'd1});
        check("t2_pend", pending, 1'b0);
        tick(1);
        check("t2_err_end", frame_err, 1'b0);
        check("t2_cfg", {fin, ain, sig_type}, {8'h40, 4'h7, 2'b10});

        // Gap timeout after two bytes, then a full valid frame
        send(8'hA5, 1'b0);
        send(8'h40, 1'b0);
        tick(GAP_T);
        check("t3_no_err_yet", frame_err, 1'b0);
        tick(1);
        check("t3_gap_err", {frame_err, err_count}, {1'b1, 8'd2});
        send_frame(8'h10, 8'h05, 8'h4F);
        check("t3_pend", pending, 1'b1);
        pulse_period();
        check("t3_cfg", {fin, ain, sig_type, cfg_update}, {8'h10, 4'h5, 2'b00, 1'b1});

        // Last-wins: two frames, one apply
        send_frame(8'h10, 8'h41, 8'h0B);
        send_frame(8'h20, 8'h41, 8'h3B);
        pulse_period();
        check("t4_cfg", {fin, ain, sig_type, cfg_update}, {8'h20, 4'h1, 2'b01, 1'b1});
        tick(3);
        pulse_period();
        check("t4_single", {cfg_update, pending}, 2'b00);

        // Reserved bits set with otherwise matching checksum
        send_frame(8'h20, 8'h61, 8'h1B);
        check("t4b_rsvd", {frame_err, err_count, pending}, {1'b1, 8'd3, 1'b0});

        // Forced apply with period_start held low
        send_frame(8'h33, 8'hC2, 8'hAB);
        n = 0;
        while (!cfg_update && n < 1000) begin
            tick(1);
            n++;
        end
        check("t5_force_lat", n, FORCE_T);
        check("t5_cfg", {fin, ain, sig_type, pending}, {8'h33, 4'h2, 2'b11, 1'b0});

        // Frame completion coinciding with period_start, nothing pending
        send(8'hA5, 1'b0);
        send(8'h55, 1'b0);
        send(8'h0A, 1'b0);
        send(8'h05, 1'b1);
        check("t6_noapply", {cfg_update, pending, fin}, {1'b0, 1'b1, 8'h33});
        // Coinciding again, now with old data pending
        send(8'hA5, 1'b0);
        send(8'h66, 1'b0);
        send(8'h4C, 1'b0);
        send(8'h70, 1'b1);
        check("t6_old_apply", {cfg_update, pending, fin, ain, sig_type}, {1'b1, 1'b1, 8'h55, 4'hA, 2'b00});
        pulse_period();
        check("t6_new_apply", {cfg_update, pending, fin, ain, sig_type}, {1'b1, 1'b0, 8'h66, 4'hC, 2'b01});

        // Error counter saturation
        for (int i = 0; i < 256; i++) send_frame(8'h01, 8'h02, 8'h00);
        check("t7_sat", err_count, 8'hFF);

        // Async reset mid-frame with a pending config
        send_frame(8'h44, 8'h83, 8'h9D);
        send(8'hA5, 1'b0);
        send(8'h11, 1'b0);
        check("t8_pre", pending, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("t8_rst", {fin, ain, sig_type, pending, err_count}, {8'h00, 4'h0, 2'b11, 1'b0, 8'h00});
`ifdef SIGGEN_CFG_READBACK_EN
        check("t8_tx", tx_valid, 1'b0);
`endif
        tick(2);
        reset = 1'b1;
        tick(1);
        send_frame(8'h44, 8'h83, 8'h9D);
        check("t8_after", pending, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/siggen_cfg_sequencer.md
Name: siggen_cfg_sequencer

Overview:
- Parses 4-byte configuration frames from the USART receive byte stream: frequency, amplitude and waveform type.
- Validates each frame, then holds it as a pending configuration.
- Applies the pending configuration to the signal-generator top only at a waveform period boundary, so output changes are glitch-free.
- Sits between the USART RX module and the generator top; drives the generator's Fin/Ain/sig_type inputs.

Parameters:
- HEADER, 8'hA5, frame start byte
- GAP_TIMEOUT, 50000, max clk cycles allowed between consecutive bytes of one frame
- FORCE_TIMEOUT, 5000000, clk cycles a pending config may wait for period_start before it is applied anyway

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- period_start  in  1  one-cycle pulse from generator at waveform phase wrap
- fin  out  8  frequency code to generator
- ain  out  4  amplitude to generator
- sig_type  out  2  00 square, 01 sine, 10 sawtooth, 11 triangular
- cfg_update  out  1  one-cycle pulse, the cycle fin/ain/sig_type change
- pending  out  1  valid config waiting for apply
- frame_err  out  1  one-cycle pulse on checksum error or gap timeout
- err_count  out  8  saturating count of frame_err pulses

Behaviour:
- Reset (async, reset=0): fin=0, ain=0, sig_type=2'b11, cfg_update=0, pending=0, frame_err=0, err_count=0, parser in IDLE, all counters 0.
- Frame format: HEADER, B1=fin, B2={sig_type[1:0], 2'b00, ain[3:0]}, B3=checksum.
  - Checksum rule: B1 XOR B2 XOR 8'h5A.
- Parser FSM, one transition per rx_valid:
  - IDLE: byte==HEADER -> GET_F; any other byte is ignored, no error.
  - GET_F: latch B1 -> GET_C.
  - GET_C: latch B2 -> GET_K.
  - GET_K: checksum ok -> load pending regs, pending=1 next cycle -> IDLE. Checksum bad -> frame_err pulse -> IDLE.
  - Any byte, including HEADER, is consumed as data in GET_F/GET_C/GET_K. There is no resync mid-frame.
  - B2 bits [5:4] must be 0; if not, treat as a checksum error.
- Gap counter:
  - Clears on every rx_valid; counts while the parser is not in IDLE.
  - Reaching GAP_TIMEOUT -> frame_err pulse, parser -> IDLE, partial frame discarded.
- Pending slot, single entry, last-wins:
  - A new valid frame overwrites pending data and restarts the force counter.
  - Apply condition: pending && (period_start || force counter == FORCE_TIMEOUT).
  - On apply: fin/ain/sig_type registered on that edge, cfg_update=1 for that one cycle, pending=0.
  - Latency: outputs change on the clk edge where period_start is sampled high.
- Simultaneous events:
  - Frame completion and period_start in the same cycle: the apply uses the old pending data if pending=1. The new frame becomes pending next cycle.
  - If pending=0 in that cycle, no apply happens.
- Identical config: a frame equal to the current outputs still goes through pending/apply and still pulses cfg_update.
- err_count saturates at 255.
- Reset mid-frame or mid-pending: everything is discarded; outputs return to reset values immediately.

Optional Feature:
- Macro: SIGGEN_CFG_READBACK_EN.
- When defined, adds these ports:
  - tx_data out 8
  - tx_valid out 1
  - tx_ready in 1
- Readback behaviour:
  - After each apply, sends 3 bytes: HEADER, fin, {sig_type,2'b00,ain}.
  - Uses a valid/ready handshake: tx_valid holds and tx_data is stable until tx_ready is sampled high.
  - If another apply occurs mid-readback, the current readback completes; one further readback of the latest values is queued (depth 1).
  - After reset, tx_valid=0.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package siggen_pkg holds:
  - sig_type encodings: SIG_SQUARE, SIG_SINE, SIG_SAW, SIG_TRI
  - HEADER default and checksum constant 8'h5A
  - parser state encoding
- One natural sub-module: siggen_frame_parser (FSM + gap counter). It outputs a frame_ok strobe with fin/ain/type, plus frame_err.
- Pending/apply logic and err_count stay in the top.

Test Plan:
- Bytes A5,40,87,(40^87^5A=9D), then period_start after 100 cycles -> pending=1 until then. On that edge fin=0x40, ain=7, sig_type=10, cfg_update one pulse.
- Frame with checksum 0x00 instead of 0x9D -> frame_err pulse, err_count=1, outputs unchanged, pending=0.
- A5,40, then no byte for GAP_TIMEOUT cycles -> frame_err pulse, parser IDLE. A following full valid frame is accepted.
- Two valid frames (fin 0x10 then 0x20) before any period_start -> a single apply with fin=0x20, a single cfg_update.
- Valid frame, period_start held low -> apply exactly FORCE_TIMEOUT cycles after pending rose.
- Assert reset low while in GET_C with pending=1 -> fin=0, ain=0, sig_type=11, pending=0 immediately. With SIGGEN_CFG_READBACK_EN, tx_valid=0 as well.
